// File: rtl/trigger_offset_pkg.sv
// Shared types and helpers for the trigger/offset timing engine.
package trigger_offset_pkg;

  typedef enum logic [1:0] {
    READY    = 2'b01,
    COUNTING = 2'b10
  } state_t;

  localparam int DEFAULT_STEP_DFLT = 1;

  // Adds two operands of width w (<= 64); sat=1 clamps to all-ones on carry, else wraps.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w, input logic sat);
    logic [64:0] sum;
    logic [64:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (65'd1 << w) - 65'd1;
    if (sat && (sum > max))
      sat_add = max[63:0];
    else
      sat_add = sum[63:0] & max[63:0];
  endfunction

endpackage

// File: rtl/trigger_offset_counter_offset_adder.sv
// Combinational a + b at DATA_W bits with optional clamp on carry.
module offset_adder
  import trigger_offset_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int SATURATE = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  assign sum = DATA_W'(sat_add(64'(a), 64'(b), DATA_W, SATURATE != 0));

endmodule

// File: rtl/trigger_offset_counter.sv
// Triggered counter with run-time limit/step, repeat and abort; the count is
// added to InSignal as an offset, with ready/done handshakes for a host FSM.
module trigger_offset_counter
  import trigger_offset_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CNT_W        = 8,
  parameter int SATURATE     = 0,
  parameter int DEFAULT_STEP = DEFAULT_STEP_DFLT
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] InSignal,
  output logic [DATA_W-1:0] OutSignal,
  input  logic              InTrigger,
  input  logic [CNT_W-1:0]  InLimit,
  input  logic [CNT_W-1:0]  InStep,
  input  logic              InRepeat,
  input  logic              InAbort,
  output logic              OutReady,
  output logic              OutDone,
  output logic [CNT_W-1:0]  OutCount
);

  localparam logic [CNT_W-1:0] STEP_DFLT = CNT_W'(DEFAULT_STEP);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_inc;
  logic [CNT_W-1:0] limit_q;
  logic [CNT_W-1:0] step_q;
  logic             repeat_q;
  logic             done_q;
  logic             terminal;
  logic [DATA_W-1:0] counter_ext;

  assign terminal = (counter >= limit_q);

  always_ff @(posedge Clock) begin
    if (Reset)
      state <= READY;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = READY;
    case (state)
      READY: begin
        state_next = InTrigger ? COUNTING : READY;
      end
      COUNTING: begin
        state_next = COUNTING;
        if (InAbort)
          state_next = READY;
        else if (terminal && !repeat_q)
          state_next = READY;
      end
      default: state_next = READY;
    endcase
  end

  // Counter and run configuration; abort wins over terminal, terminal over increment.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      counter  <= '0;
      limit_q  <= '0;
      step_q   <= STEP_DFLT;
      repeat_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        READY: begin
          if (InTrigger) begin
            counter  <= '0;
            limit_q  <= InLimit;
            step_q   <= (InStep == '0) ? STEP_DFLT : InStep;
            repeat_q <= InRepeat;
          end
        end
        COUNTING: begin
          if (InAbort) begin
            counter <= '0;
          end else if (terminal) begin
            done_q <= 1'b1;
            if (repeat_q)
              counter <= '0;
          end else begin
            counter <= counter_inc;
          end
        end
        default: ;
      endcase
    end
  end

  offset_adder #(
    .DATA_W   (CNT_W),
    .SATURATE (1)
  ) u_inc (
    .a   (counter),
    .b   (step_q),
    .sum (counter_inc)
  );

  assign counter_ext = DATA_W'(counter);

  offset_adder #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_offset (
    .a   (InSignal),
    .b   (counter_ext),
    .sum (OutSignal)
  );

  assign OutReady = (state == READY);
  assign OutDone  = done_q;
  assign OutCount = counter;

endmodule

// File: tb/tb_trigger_offset_counter.sv
// Directed bench: wrap, saturating and 4-bit-counter instances of trigger_offset_counter.
module tb_trigger_offset_counter;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] sig;
  logic [7:0] limit;
  logic [7:0] step;
  logic [3:0] lim4;
  logic [3:0] step4;
  logic       rpt;
  logic       abort;
  logic       trig_main;
  logic       trig_sat;
  logic       trig_n;

  logic [7:0] m_sig, s_sig, n_sig;
  logic [7:0] m_cnt, s_cnt;
  logic [3:0] n_cnt;
  logic       m_rdy, m_done, s_rdy, s_done, n_rdy, n_done;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  trigger_offset_counter #(.DATA_W(8), .CNT_W(8), .SATURATE(0)) dut_main (
    .Clock(Clock), .Reset(Reset), .InSignal(sig), .OutSignal(m_sig),
    .InTrigger(trig_main), .InLimit(limit), .InStep(step), .InRepeat(rpt),
    .InAbort(abort), .OutReady(m_rdy), .OutDone(m_done), .OutCount(m_cnt));

  trigger_offset_counter #(.DATA_W(8), .CNT_W(8), .SATURATE(1)) dut_sat (
    .Clock(Clock), .Reset(Reset), .InSignal(sig), .OutSignal(s_sig),
    .InTrigger(trig_sat), .InLimit(limit), .InStep(step), .InRepeat(rpt),
    .InAbort(abort), .OutReady(s_rdy), .OutDone(s_done), .OutCount(s_cnt));

  trigger_offset_counter #(.DATA_W(8), .CNT_W(4), .SATURATE(0)) dut_n (
    .Clock(Clock), .Reset(Reset), .InSignal(sig), .OutSignal(n_sig),
    .InTrigger(trig_n), .InLimit(lim4), .InStep(step4), .InRepeat(rpt),
    .InAbort(abort), .OutReady(n_rdy), .OutDone(n_done), .OutCount(n_cnt));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] l,
                               input logic [7:0] st, input logic r);
    sig   = s;
    limit = l;
    step  = st;
    rpt   = r;
  endtask

  initial begin
    Reset = 1'b1; sig = 8'd5; limit = '0; step = '0; lim4 = '0; step4 = '0;
    rpt = 1'b0; abort = 1'b0; trig_main = 1'b0; trig_sat = 1'b0; trig_n = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    checkOutput("rst_ready", m_rdy, 1);
    checkOutput("rst_count", m_cnt, 0);
    checkOutput("rst_done", m_done, 0);
    checkOutput("rst_signal", m_sig, 5);

    // limit 10, step 0 -> default step 1
    applyStimulus(8'd5, 8'd10, 8'd0, 1'b0);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    checkOutput("t1_start_cnt", m_cnt, 0);
    checkOutput("t1_start_rdy", m_rdy, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("t1_cnt%0d", k), m_cnt, k);
      checkOutput($sformatf("t1_sig%0d", k), m_sig, 5 + k);
      checkOutput($sformatf("t1_done%0d", k), m_done, 0);
    end
    tick();
    checkOutput("t1_done", m_done, 1);
    checkOutput("t1_final_cnt", m_cnt, 10);
    checkOutput("t1_ready", m_rdy, 1);
    tick();
    checkOutput("t1_done_once", m_done, 0);

    // step 3 overshoot; trigger held through the terminal edge is not accepted
    applyStimulus(8'd5, 8'd10, 8'd3, 1'b0);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("t2_cnt%0d", k), m_cnt, 3 * k);
    end
    trig_main = 1'b1;
    tick();
    checkOutput("t2_done", m_done, 1);
    checkOutput("t2_hold12", m_cnt, 12);
    checkOutput("t2_ready", m_rdy, 1);
    tick();
    trig_main = 1'b0;
    checkOutput("t2_retrig_rdy", m_rdy, 0);
    checkOutput("t2_retrig_cnt", m_cnt, 0);
    checkOutput("t2_retrig_done", m_done, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    checkOutput("t2_abort_rdy", m_rdy, 1);

    // repeat mode, limit 2
    applyStimulus(8'd0, 8'd2, 8'd1, 1'b1);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    rpt = 1'b0;
    for (int p = 0; p < 2; p++) begin
      tick(); checkOutput("t3_c1", m_cnt, 1); checkOutput("t3_d1", m_done, 0);
      tick(); checkOutput("t3_c2", m_cnt, 2);
      tick(); checkOutput("t3_c0", m_cnt, 0); checkOutput("t3_pulse", m_done, 1);
      checkOutput("t3_busy", m_rdy, 0);
    end
    tick(); checkOutput("t3_c1b", m_cnt, 1);
    abort = 1'b1; tick();
    checkOutput("t3_abort_cnt", m_cnt, 0);
    checkOutput("t3_abort_rdy", m_rdy, 1);
    checkOutput("t3_abort_done", m_done, 0);
    tick(); abort = 1'b0;
    checkOutput("t3_abort_ready_ignored", m_rdy, 1);

    // InSignal 250: wrap vs clamp
    applyStimulus(8'd250, 8'd10, 8'd1, 1'b0);
    trig_main = 1'b1; trig_sat = 1'b1; tick(); trig_main = 1'b0; trig_sat = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checkOutput($sformatf("t4_sat%0d", k), s_sig, (250 + k > 255) ? 255 : 250 + k);
      checkOutput($sformatf("t4_wrap%0d", k), m_sig, (250 + k) % 256);
    end
    tick();
    checkOutput("t4_sat_done", s_done, 1);
    checkOutput("t4_wrap_done", m_done, 1);

    // mid-run reset with ignored re-trigger pulses
    applyStimulus(8'd5, 8'd10, 8'd1, 1'b0);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    tick(); tick();
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    checkOutput("t5_retrig_ignored3", m_cnt, 3);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    checkOutput("t5_cnt4", m_cnt, 4);
    Reset = 1'b1; tick(); Reset = 1'b0;
    checkOutput("t5_rst_cnt", m_cnt, 0);
    checkOutput("t5_rst_rdy", m_rdy, 1);
    checkOutput("t5_rst_done", m_done, 0);

    // limit 0: done one edge after the trigger
    applyStimulus(8'd5, 8'd0, 8'd1, 1'b0);
    trig_main = 1'b1; tick(); trig_main = 1'b0;
    checkOutput("t6_busy", m_rdy, 0);
    tick();
    checkOutput("t6_done", m_done, 1);
    checkOutput("t6_ready", m_rdy, 1);

    // 4-bit counter saturates at 15 instead of wrapping
    lim4 = 4'd15; step4 = 4'd7;
    trig_n = 1'b1; tick(); trig_n = 1'b0;
    checkOutput("t7_c0", n_cnt, 0);
    tick(); checkOutput("t7_c7", n_cnt, 7);
    tick(); checkOutput("t7_c14", n_cnt, 14);
    tick(); checkOutput("t7_c15", n_cnt, 15);
    checkOutput("t7_nodone", n_done, 0);
    tick();
    checkOutput("t7_done", n_done, 1);
    checkOutput("t7_hold", n_cnt, 15);
    checkOutput("t7_ready", n_rdy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trigger_offset_counter.md
Name: trigger_offset_counter

Overview:
Parametrised successor to the single-channel trigger/count/offset entity. A trigger starts a counter that runs up to a run-time limit in a run-time step size, with an optional repeat mode and an abort input. While it runs, the current count is added to a data input, with wrap-around or saturation selected at build time. The block sits behind the external-package interface as a drop-in timing/offset engine, with ready/done handshake outputs for a host FSM.

Parameters:
DATA_W, 8, width of InSignal/OutSignal
CNT_W, 8, width of counter, InLimit, InStep, OutCount
SATURATE, 0, 0 = OutSignal wraps modulo 2^DATA_W; 1 = OutSignal clamps at 2^DATA_W-1
DEFAULT_STEP, 1, step used when InStep = 0

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  reset, synchronous, active-high
InSignal  in  DATA_W  data operand
OutSignal  out  DATA_W  InSignal + counter (combinational)
InTrigger  in  1  start request, sampled in READY only
InLimit  in  CNT_W  terminal count, latched on accepted trigger
InStep  in  CNT_W  increment, latched on accepted trigger; 0 means DEFAULT_STEP
InRepeat  in  1  1 = restart automatically at terminal; latched on trigger
InAbort  in  1  cancel run, effective in COUNTING only
OutReady  out  1  1 when state = READY (combinational from state)
OutDone  out  1  registered one-cycle pulse on terminal count
OutCount  out  CNT_W  current counter value

Behaviour:
- Reset (synchronous, Clock edge with Reset=1), overriding all other inputs:
  - counter=0, state=READY, OutDone=0.
  - Latched limit/step/repeat = 0/DEFAULT_STEP/0.
  - Outputs after reset: OutReady=1, OutCount=0, OutSignal=InSignal.
- States: READY, COUNTING. Any illegal encoding goes to READY on the next edge.
- READY:
  - InTrigger=1: latch InLimit, step (InStep, or DEFAULT_STEP if 0) and InRepeat; counter<=0; go to COUNTING.
  - InAbort is ignored in READY. Counter holds its value otherwise.
- COUNTING, evaluated in priority order each edge:
  1. InAbort=1: counter<=0, go to READY, no OutDone.
  2. counter >= limit_q (terminal): OutDone<=1 for exactly one cycle. If repeat_q=1, counter<=0 and stay in COUNTING; otherwise counter holds, go to READY.
  3. Otherwise: counter <= counter + step_q, saturating at 2^CNT_W-1 (no wrap).
- InTrigger is ignored in COUNTING; there is no re-trigger.
- Latency: trigger accepted at edge 0; OutReady falls after edge 0. For step 1 and limit L, the terminal edge is edge L+1. OutDone is high, and OutReady is high again, during the cycle after that edge. Limit 0 gives done one edge after the trigger.
- The >= compare covers a step that overshoots the limit. The final count is then the overshoot value, not the limit.
- OutSignal arithmetic:
  - The counter is zero-extended, or truncated to its low bits, to DATA_W.
  - The sum is DATA_W+1 wide internally. Wrap keeps the low DATA_W bits; SATURATE=1 clamps on carry.
- Reset mid-run aborts immediately with no OutDone.
- Trigger asserted on the same edge as a non-repeat terminal is not accepted; the state is still COUNTING on that edge.

Decomposition:
- Package trigger_offset_pkg holds:
  - the state enum (READY, COUNTING);
  - the DEFAULT_STEP default;
  - a saturating-add function, parameterised by width.
- One natural sub-module: offset_adder (DATA_W, SATURATE), the combinational InSignal + counter with optional clamp. Reused for the counter increment, with width CNT_W and saturation always on.

Test Plan:
- Reset, then InTrigger one cycle with InLimit=10, InStep=0, InSignal=5 -> OutCount runs 0..10; OutSignal runs 5..15; OutDone is a single pulse the cycle after the edge with OutCount=10; OutReady=1 afterwards.
- InLimit=10, InStep=3 -> OutCount runs 0,3,6,9,12; done at 12; non-repeat returns to READY holding 12.
- InRepeat=1, InLimit=2, step 1 -> OutCount cycles 0,1,2,0,1,2; OutDone pulses every 3 cycles; OutReady stays 0 until InAbort, then OutCount=0 and OutReady=1 with no OutDone.
- DATA_W=8, SATURATE=1, InSignal=250, limit 10 -> OutSignal clamps at 255 from count 5; with SATURATE=0 it wraps to 0 at count 6.
- Reset asserted at count 4 mid-run -> next cycle OutCount=0, OutReady=1, OutDone=0. InTrigger pulses during COUNTING have no effect on the count sequence.
- CNT_W=4, InLimit=15, InStep=7 -> counter runs 0,7,14 then saturates at 15 (no wrap to 5); done at 15.
